// File: rtl/ooo_pkg.sv
// Shared types and helpers for the decoder-to-dispatch interface:
// register-field encoding, the micro-op record and field decode helpers.
package ooo_pkg;

  localparam int REG_FIELD_W = 5;
  localparam int REG_IDX_W   = 4;
  localparam int FUID_W      = 4;
  localparam int FLAG_W      = 8;
  localparam int NUM_SRC     = 2;

  // Register field: {idx, active}. All-zero means "no register".
  typedef logic [REG_FIELD_W-1:0] reg_field_t;

  typedef struct packed {
    reg_field_t [NUM_SRC-1:0] readregs;
    reg_field_t               writereg;
    logic [FLAG_W-1:0]        flags;
    logic [FUID_W-1:0]        fuid;
  } uop_t;

  // A field names a register only when its low bit is set.
  function automatic logic reg_active(input reg_field_t field);
    return field[0];
  endfunction

  // Architectural register index carried in the upper bits of a field.
  function automatic logic [REG_IDX_W-1:0] reg_idx(input reg_field_t field);
    return field[REG_FIELD_W-1:1];
  endfunction

endpackage

// File: rtl/dispatch_scoreboard_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// writing micro-op issues and cleared on writeback. Also answers whether a
// held micro-op's registers are hazard-free, including same-cycle writeback
// bypass.
module dispatch_scoreboard_scoreboard
  import ooo_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      wb_valid,
  input  reg_field_t                wb_reg,
  input  logic                      set_valid,
  input  reg_field_t                set_reg,
  input  reg_field_t [NUM_SRC-1:0]  query_readregs,
  input  reg_field_t                query_writereg,
  output logic                      query_ready,
  output logic [NUM_REGS-1:0]       pending
);

  logic [NUM_REGS-1:0] pending_r;
  logic [NUM_REGS-1:0] pending_next_s;
  logic [NUM_SRC-1:0]  src_clear_s;
  logic                dst_clear_s;

  // A field is clear if unused, not pending, or written back this very cycle.
  function automatic logic field_clear(
    input reg_field_t          field,
    input logic [NUM_REGS-1:0] pend,
    input logic                wbv,
    input reg_field_t          wbr
  );
    logic bypass;
    bypass = wbv && reg_active(wbr) && (wbr == field);
    return !reg_active(field) || !pend[reg_idx(field)] || bypass;
  endfunction

  // Hazard query for every source and the destination of the held op.
  always_comb begin
    src_clear_s = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      src_clear_s[i] = field_clear(query_readregs[i], pending_r, wb_valid, wb_reg);
    end
    dst_clear_s = field_clear(query_writereg, pending_r, wb_valid, wb_reg);
  end

  assign query_ready = (&src_clear_s) && dst_clear_s;
  assign pending     = pending_r;

  // Next scoreboard: writeback clear first, then issue set, so a set wins.
  always_comb begin
    pending_next_s = pending_r;
    if (wb_valid && reg_active(wb_reg)) begin
      pending_next_s[reg_idx(wb_reg)] = 1'b0;
    end else begin
      pending_next_s = pending_r;
    end
    if (set_valid && reg_active(set_reg)) begin
      pending_next_s[reg_idx(set_reg)] = 1'b1;
    end else begin
      pending_next_s[0] = pending_next_s[0];
    end
  end

  // Scoreboard register; flush and reset wipe every outstanding write.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pending_r <= {NUM_REGS{1'b0}};
    end else begin
      pending_r <= pending_next_s;
    end
  end

endmodule

// File: rtl/dispatch_scoreboard.sv
// Dispatch stage: holds one decoded micro-op and issues it to the
// functional-unit bus once RAW/WAW register hazards and FU-busy are clear.
// Counts cycles in which a held op could not issue.
module dispatch_scoreboard
  import ooo_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int NUM_FU   = 16,
  parameter int STALL_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  reg_field_t [NUM_SRC-1:0]  in_readregs,
  input  reg_field_t                in_writereg,
  input  logic [FLAG_W-1:0]         in_flags,
  input  logic [FUID_W-1:0]         in_fuid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output reg_field_t [NUM_SRC-1:0]  out_readregs,
  output reg_field_t                out_writereg,
  output logic [FLAG_W-1:0]         out_flags,
  output logic [FUID_W-1:0]         out_fuid,
  input  logic [NUM_FU-1:0]         fu_busy,
  input  logic                      wb_valid,
  input  reg_field_t                wb_reg,
  input  logic                      flush,
  output logic [NUM_REGS-1:0]       pending,
  output logic [STALL_W-1:0]        stall_cycles
);

  uop_t               hold_r;
  logic               hold_valid_r;
  logic [STALL_W-1:0] stall_r;

  uop_t in_uop_s;
  logic regs_clear_s;
  logic fu_free_s;
  logic issue_ok_s;
  logic fire_s;
  logic in_ready_s;
  logic accept_s;

  dispatch_scoreboard_scoreboard #(
    .NUM_REGS(NUM_REGS)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .set_valid     (fire_s),
    .set_reg       (hold_r.writereg),
    .query_readregs(hold_r.readregs),
    .query_writereg(hold_r.writereg),
    .query_ready   (regs_clear_s),
    .pending       (pending)
  );

  // Pack the incoming decoder fields into one micro-op record.
  always_comb begin
    in_uop_s.readregs = in_readregs;
    in_uop_s.writereg = in_writereg;
    in_uop_s.flags    = in_flags;
    in_uop_s.fuid     = in_fuid;
  end

  // Issue/accept handshake; nothing issues or is accepted while flushing.
  always_comb begin
    fu_free_s  = !fu_busy[hold_r.fuid];
    issue_ok_s = hold_valid_r && regs_clear_s && fu_free_s && !flush;
    fire_s     = issue_ok_s && out_ready;
    in_ready_s = !flush && (!hold_valid_r || fire_s);
    accept_s   = in_valid && in_ready_s;
  end

  // Output view of the hold register; zero whenever the stage is empty.
  always_comb begin
    out_valid    = issue_ok_s;
    in_ready     = in_ready_s;
    stall_cycles = stall_r;
    if (hold_valid_r) begin
      out_readregs = hold_r.readregs;
      out_writereg = hold_r.writereg;
      out_flags    = hold_r.flags;
      out_fuid     = hold_r.fuid;
    end else begin
      out_readregs = {NUM_SRC{5'b00000}};
      out_writereg = 5'b00000;
      out_flags    = 8'h00;
      out_fuid     = 4'h0;
    end
  end

  // One-entry hold stage: capture on accept, empty on issue or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_r <= 1'b0;
      hold_r       <= '0;
    end else if (flush) begin
      hold_valid_r <= 1'b0;
    end else if (accept_s) begin
      hold_valid_r <= 1'b1;
      hold_r       <= in_uop_s;
    end else if (fire_s) begin
      hold_valid_r <= 1'b0;
    end else begin
      hold_valid_r <= hold_valid_r;
    end
  end

  // Saturating count of cycles a held op was blocked; survives flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r <= {STALL_W{1'b0}};
    end else if (hold_valid_r && !issue_ok_s && (stall_r != {STALL_W{1'b1}})) begin
      stall_r <= stall_r + {{(STALL_W-1){1'b0}}, 1'b1};
    end else begin
      stall_r <= stall_r;
    end
  end

endmodule

// File: tb/tb_dispatch_scoreboard.sv
// Self-checking bench for dispatch_scoreboard: directed scenarios plus a
// randomized run, all compared against a behavioural model of the stage.
module tb_dispatch_scoreboard;
  import ooo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, out_ready, wb_valid, flush;
  reg_field_t [1:0] in_readregs;
  reg_field_t       in_writereg, wb_reg;
  logic [7:0]       in_flags;
  logic [3:0]       in_fuid;
  logic [15:0]      fu_busy;
  logic             in_ready, out_valid;
  reg_field_t [1:0] out_readregs;
  reg_field_t       out_writereg;
  logic [7:0]       out_flags;
  logic [3:0]       out_fuid;
  logic [15:0]      pending;
  logic [15:0]      stall_cycles;

  int errors = 0;
  int checks = 0;

  dispatch_scoreboard dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_readregs(in_readregs), .in_writereg(in_writereg), .in_flags(in_flags),
    .in_fuid(in_fuid), .out_valid(out_valid), .out_ready(out_ready),
    .out_readregs(out_readregs), .out_writereg(out_writereg), .out_flags(out_flags),
    .out_fuid(out_fuid), .fu_busy(fu_busy), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .flush(flush), .pending(pending), .stall_cycles(stall_cycles)
  );

  // Behavioural model of the stage.
  bit         m_hv;
  logic [4:0] m_src [2];
  logic [4:0] m_dst;
  logic [7:0] m_flags;
  logic [3:0] m_fuid;
  bit         m_pend [16];
  int         m_stall;

  function automatic bit m_blocked(input logic [4:0] f);
    if (f[0] == 1'b0) return 1'b0;
    if (!m_pend[f[4:1]]) return 1'b0;
    if (wb_valid && wb_reg == f) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_out_valid();
    if (!m_hv || flush) return 1'b0;
    if (m_blocked(m_src[0]) || m_blocked(m_src[1]) || m_blocked(m_dst)) return 1'b0;
    return !fu_busy[m_fuid];
  endfunction

  function automatic bit m_in_ready();
    return !flush && (!m_hv || (m_out_valid() && out_ready));
  endfunction

  function automatic logic [15:0] m_pend_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [37:0] m_fields();
    if (!m_hv) return 38'd0;
    return {m_src[1], m_src[0], m_dst, m_flags, m_fuid};
  endfunction

  // Advance one clock and update the model with the same inputs.
  task automatic tick();
    bit ov, fire, acc;
    ov   = m_out_valid();
    fire = ov && out_ready;
    acc  = in_valid && m_in_ready();
    @(posedge clk);
    if (rst) begin
      m_hv = 1'b0; m_stall = 0;
      for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
    end else begin
      if (m_hv && !ov && m_stall < 65535) m_stall++;
      if (flush) begin
        m_hv = 1'b0;
        for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
      end else begin
        if (wb_valid && wb_reg[0]) m_pend[wb_reg[4:1]] = 1'b0;
        if (fire && m_dst[0]) m_pend[m_dst[4:1]] = 1'b1;
        if (acc) begin
          m_hv = 1'b1; m_src[0] = in_readregs[0]; m_src[1] = in_readregs[1];
          m_dst = in_writereg; m_flags = in_flags; m_fuid = in_fuid;
        end else if (fire) begin
          m_hv = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_readregs = '0; in_writereg = 5'd0; in_flags = 8'd0;
    in_fuid = 4'd0; out_ready = 1'b1; fu_busy = 16'd0; wb_valid = 1'b0;
    wb_reg = 5'd0; flush = 1'b0;
  endtask

  task automatic op(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] d,
                    input logic [7:0] fl, input logic [3:0] fu);
    in_valid = 1'b1; in_readregs[0] = s0; in_readregs[1] = s1;
    in_writereg = d; in_flags = fl; in_fuid = fu;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    checks++; if (pending !== 16'h0) begin errors++; $display("FAIL reset_pending: got %h expected 0000", pending); end
    checks++; if (stall_cycles !== 16'h0) begin errors++; $display("FAIL reset_stall: got %h expected 0000", stall_cycles); end
    checks++; if ({out_readregs, out_writereg, out_flags, out_fuid} !== 38'd0) begin errors++; $display("FAIL reset_fields: got %h expected 0", {out_readregs, out_writereg, out_flags, out_fuid}); end
  endtask

  task automatic test_basic_issue();
    idle(); op(5'h03, 5'h05, 5'h07, 8'hA5, 4'd2); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %0b expected 1", in_ready); end
    tick();
    in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %0b expected 1", out_valid); end
    checks++; if (out_fuid !== 4'd2 || out_flags !== 8'hA5 || out_writereg !== 5'h07 || out_readregs[0] !== 5'h03 || out_readregs[1] !== 5'h05) begin
      errors++; $display("FAIL basic_fields: got %h expected %h", {out_readregs, out_writereg, out_flags, out_fuid}, {5'h05, 5'h03, 5'h07, 8'hA5, 4'd2}); end
    tick(); #1;
    checks++; if (pending[3] !== 1'b1) begin errors++; $display("FAIL basic_pending3: got %0b expected 1", pending[3]); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %0b expected 0", out_valid); end
  endtask

  task automatic test_raw_bypass();
    int s0;
    idle(); op(5'h07, 5'h00, 5'h0B, 8'h11, 4'd1);
    tick();
    in_valid = 1'b0; s0 = m_stall; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_blocked: got %0b expected 0", out_valid); end
    tick(); tick(); #1;
    checks++; if (stall_cycles !== 16'(s0 + 2)) begin errors++; $display("FAIL raw_stall_count: got %0d expected %0d", stall_cycles, s0 + 2); end
    wb_valid = 1'b1; wb_reg = 5'h07; #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL raw_bypass: got %0b expected 1", out_valid); end
    tick();
    wb_valid = 1'b0; #1;
    checks++; if (pending[3] !== 1'b0 || pending[5] !== 1'b1) begin errors++; $display("FAIL raw_pending_after: got %h expected bit3=0 bit5=1", pending); end
    checks++; if (stall_cycles !== 16'(s0 + 2)) begin errors++; $display("FAIL raw_stall_hold: got %0d expected %0d", stall_cycles, s0 + 2); end
  endtask

  task automatic test_fu_busy();
    idle(); fu_busy[4] = 1'b1; wb_valid = 1'b1; wb_reg = 5'h0B;
    op(5'h00, 5'h00, 5'h0D, 8'h22, 4'd4);
    tick();
    wb_valid = 1'b0; op(5'h00, 5'h00, 5'h11, 8'h3C, 4'd4); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL fu_busy_block: got valid=%0b ready=%0b expected 0/0", out_valid, in_ready); end
    tick();
    fu_busy[4] = 1'b0; #1;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL fu_free_issue: got valid=%0b ready=%0b expected 1/1", out_valid, in_ready); end
    tick();
    in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b1 || out_flags !== 8'h3C) begin errors++; $display("FAIL fu_next_captured: got valid=%0b flags=%h expected 1/3c", out_valid, out_flags); end
    checks++; if (pending[6] !== 1'b1) begin errors++; $display("FAIL fu_pending6: got %0b expected 1", pending[6]); end
    tick();
  endtask

  task automatic test_same_cycle_wb_set();
    idle(); op(5'h00, 5'h00, 5'h09, 8'h01, 4'd0);
    tick();
    op(5'h00, 5'h00, 5'h09, 8'h02, 4'd0);
    tick();
    in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL waw_blocked: got %0b expected 0", out_valid); end
    wb_valid = 1'b1; wb_reg = 5'h09; #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL waw_bypass: got %0b expected 1", out_valid); end
    tick();
    wb_valid = 1'b0; #1;
    checks++; if (pending[4] !== 1'b1) begin errors++; $display("FAIL set_wins: got %0b expected 1", pending[4]); end
  endtask

  task automatic test_back_to_back();
    int free_idx[$];
    for (int i = 0; i < 16; i++) if (!m_pend[i]) free_idx.push_back(i);
    idle();
    for (int k = 0; k < free_idx.size(); k++) begin
      op(5'h00, 5'h00, {4'(free_idx[k]), 1'b1}, 8'(k), 4'(k)); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %0b expected 1 at op %0d", in_ready, k); end
      if (k > 0) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %0b expected 1 at op %0d", out_valid, k); end
      end
      tick();
    end
    in_valid = 1'b0;
    tick(); #1;
    checks++; if (pending !== 16'hFFFF) begin errors++; $display("FAIL b2b_pending_full: got %h expected ffff", pending); end
  endtask

  task automatic test_unused_fields();
    idle(); op(5'h00, 5'h00, 5'h00, 8'h5A, 4'd7);
    tick();
    in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL unused_issue: got %0b expected 1", out_valid); end
    tick(); #1;
    checks++; if (pending !== 16'hFFFF) begin errors++; $display("FAIL unused_no_touch: got %h expected ffff", pending); end
  endtask

  task automatic test_flush();
    idle(); op(5'h07, 5'h00, 5'h00, 8'h77, 4'd1);
    tick();
    op(5'h00, 5'h00, 5'h00, 8'h88, 4'd2); flush = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %0b expected 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || pending !== 16'h0 || out_flags !== 8'h00) begin errors++; $display("FAIL flush_cleared: got valid=%0b pending=%h flags=%h expected 0/0000/00", out_valid, pending, out_flags); end
    checks++; if (stall_cycles !== 16'(m_stall) || stall_cycles == 16'h0) begin errors++; $display("FAIL flush_stall_kept: got %0d expected %0d", stall_cycles, m_stall); end
  endtask

  task automatic test_random();
    idle();
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom % 4) != 0;
      for (int s = 0; s < 2; s++) in_readregs[s] = ($urandom % 3 == 0) ? 5'h00 : {4'($urandom % 6), 1'b1};
      in_writereg = ($urandom % 3 == 0) ? 5'h00 : {4'($urandom % 6), 1'b1};
      in_flags = 8'($urandom); in_fuid = 4'($urandom % 4);
      fu_busy = ($urandom % 4 == 0) ? (16'h1 << ($urandom % 4)) : 16'h0;
      wb_valid = $urandom % 2; wb_reg = ($urandom % 4 == 0) ? 5'h00 : {4'($urandom % 6), 1'b1};
      out_ready = ($urandom % 4) != 0; flush = ($urandom % 40) == 0;
      #1;
      checks++; if (out_valid !== m_out_valid()) begin errors++; $display("FAIL rnd_out_valid c%0d: got %0b expected %0b", c, out_valid, m_out_valid()); end
      checks++; if (in_ready !== m_in_ready()) begin errors++; $display("FAIL rnd_in_ready c%0d: got %0b expected %0b", c, in_ready, m_in_ready()); end
      checks++; if (pending !== m_pend_vec()) begin errors++; $display("FAIL rnd_pending c%0d: got %h expected %h", c, pending, m_pend_vec()); end
      checks++; if (stall_cycles !== 16'(m_stall)) begin errors++; $display("FAIL rnd_stall c%0d: got %0d expected %0d", c, stall_cycles, m_stall); end
      checks++; if ({out_readregs, out_writereg, out_flags, out_fuid} !== m_fields()) begin errors++; $display("FAIL rnd_fields c%0d: got %h expected %h", c, {out_readregs, out_writereg, out_flags, out_fuid}, m_fields()); end
      tick();
    end
  endtask

  task automatic test_stall_saturate();
    idle(); fu_busy[5] = 1'b1; op(5'h00, 5'h00, 5'h00, 8'h99, 4'd5);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 65540; c++) tick();
    #1;
    checks++; if (stall_cycles !== 16'hFFFF || out_valid !== 1'b0) begin errors++; $display("FAIL stall_saturate: got %h valid=%0b expected ffff/0", stall_cycles, out_valid); end
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL stall_sat_flush: got %h expected ffff", stall_cycles); end
  endtask

  initial begin
    idle(); rst = 1'b1;
    m_hv = 1'b0; m_stall = 0; m_dst = 5'd0; m_flags = 8'd0; m_fuid = 4'd0;
    m_src[0] = 5'd0; m_src[1] = 5'd0;
    for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
    test_reset();
    test_basic_issue();
    test_raw_bypass();
    test_fu_busy();
    test_same_cycle_wb_set();
    test_back_to_back();
    test_unused_fields();
    test_flush();
    test_random();
    test_stall_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dispatch_scoreboard.md
Name: dispatch_scoreboard

Overview:
- Consumer end of the decoder's output interface.
- Accepts one decoded micro-op per cycle (read regs, write reg, flags, FU id) over a valid/ready handshake and holds it in a one-entry stage.
- Issues the micro-op to the functional-unit bus only when these hazards are resolved: RAW on sources, WAW on destination, FU busy.
- Keeps a per-register pending-write scoreboard that is set on issue and cleared on writeback.

Parameters:
- NUM_REGS, 16, architectural registers; register field is {idx[3:0], valid bit}.
- NUM_FU, 16, functional units addressable by fuid.
- STALL_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  decoded micro-op present
- in_ready  output  1  stage can accept
- in_readregs  input  2x5  source regs; 5'b0 = unused, else {idx,1'b1}
- in_writereg  input  5  dest reg; 5'b0 = none
- in_flags  input  8  decoder flag byte, passed through
- in_fuid  input  4  target functional unit
- out_valid  output  1  micro-op issuable this cycle
- out_ready  input  1  FU bus accepts
- out_readregs  output  2x5  held sources
- out_writereg  output  5  held dest
- out_flags  output  8  held flags
- out_fuid  output  4  held FU id
- fu_busy  input  NUM_FU  per-FU busy mask
- wb_valid  input  1  writeback event
- wb_reg  input  5  writeback dest, same encoding
- flush  input  1  discard held op, clear scoreboard
- pending  output  NUM_REGS  scoreboard state (debug/verification)
- stall_cycles  output  STALL_W  saturating count of blocked cycles

Behaviour:
- Reset (clk edge with rst=1) sets:
  - hold_valid=0, pending=0, stall_cycles=0;
  - all out_* fields=0, out_valid=0;
  - in_ready=1 from the first cycle after reset.
- Encoding: a register field is active only if bit0=1; idx=field[4:1].
  - Inactive fields never read or modify pending.
- Hold register:
  - in_ready = !hold_valid || fire, where fire = out_valid && out_ready.
  - On in_valid && in_ready, capture all in_* fields and set hold_valid=1.
  - When fire occurs without a new capture, hold_valid=0.
- Latency: an op accepted at edge N can assert out_valid in cycle N+1 at the earliest. Back-to-back throughput is 1/cycle when there are no hazards.
- Issue condition, out_valid = hold_valid && all of:
  - each active source has pending[idx]==0, or wb_valid with a matching active wb_reg this cycle (bypass);
  - the active dest has pending[idx]==0, or the same bypass applies;
  - fu_busy[out_fuid]==0.
- out_valid is independent of out_ready.
- out_* fields reflect the hold register whenever hold_valid=1; they are 0 otherwise.
- Scoreboard update each edge:
  - the wb clear is applied first;
  - then, on fire with an active dest, pending[dest idx] is set.
  - Same reg cleared and set in the same cycle: the set wins (ends 1).
- A writeback to an idx that is not pending is a no-op.
- Flush (priority over everything except rst):
  - next cycle hold_valid=0, pending=0;
  - in_valid in the flush cycle is ignored and in_ready=0 during flush;
  - stall_cycles is not cleared.
- stall_cycles increments when hold_valid && !out_valid, and saturates at all-ones.
- A micro-op whose dest equals its own source is legal; its own issue sets pending after it reads.
- Reset mid-stall drops the held op. Nothing is issued afterwards.

Decomposition:
- Shared package ooo_pkg holds:
  - REG_FIELD_W=5, FUID_W=4, FLAG_W=8;
  - typedef reg_field_t and typedef uop_t {readregs, writereg, flags, fuid};
  - a function reg_active() and a function reg_idx().
- Sub-module scoreboard holds the pending vector, set/clear logic and the bypass-aware ready query. The top level holds the handshake, flush logic and counter.

Test Plan:
- Reset, then in_valid with sources {0x03,0x05}, dest 0x07, fuid 2, out_ready=1 -> out_valid next cycle, fuid 2; pending[3]=1 the cycle after that.
- Issue dest 0x07 (idx3), then an op reading 0x07 -> out_valid=0 and stall_cycles increments each cycle. wb_valid with wb_reg=0x07 on cycle k -> out_valid=1 in cycle k (bypass), and pending[3]=0 after the edge unless re-set.
- fu_busy[4]=1 with held op fuid 4 -> out_valid=0 and in_ready=0. fu_busy[4] drops -> issue, in_ready=1 the same cycle, and a new op is captured on that edge.
- Same-cycle writeback of 0x09 and issue of an op with dest 0x09 -> pending[4]=1 afterwards.
- Sources/dest all 5'b0 with pending=all-ones -> issues immediately when the FU is free.
- Flush while held op is stalled on pending[3] -> hold_valid=0, pending=0, out_valid=0 the next cycle; stall_cycles retained. Forcing 0xFFFF stalls -> counter stays 0xFFFF.
